adc_spi_rx: RTL and testbench

//  Upstream sample source for the FIR chain: reads a serial (SPI-style) ADC, converts
//  its unsigned offset-binary word to a signed 9-bit sample, and presents it on a

---
 rtl/fir_pkg.sv | 15 +
 rtl/adc_sclk_gen.sv | 50 +++++
 rtl/adc_spi_rx.sv | 171 +++++++++++++++++
 tb/tb_adc_spi_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample path and its ADC front end.
// No logic; types and widths only.
package fir_pkg;

    localparam int SAMP_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DONE,
        GAP
    } adc_state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK half-period timer for the ADC serial reader: ticks on the edges that raise/lower SCLK.
// Latency: combinational ticks from registered count. Runs only while run=1, otherwise held cleared.
module adc_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic rise_tick,
    output logic fall_tick,
    output logic period_done
);

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          half_end;

    assign half_end    = run && (cnt_q == CW'(SCLK_DIV - 1));
    assign rise_tick   = half_end && !phase_q;
    assign fall_tick   = half_end && phase_q;
    assign period_done = fall_tick;

    // phase 0 = SCLK low half, phase 1 = SCLK high half
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/adc_spi_rx.sv
// Reads an offset-binary SPI ADC MSB first and publishes signed samples on valid/ready.
// Latency: sample valid SCLK_DIV+1 cycles after the last sampling edge. A new sample overwrites an unaccepted one and sets sticky overrun.
module adc_spi_rx
    import fir_pkg::*;
#(
    parameter int ADC_BITS  = 12,
    parameter int OUT_W     = SAMP_W,
    parameter int SCLK_DIV  = 2,
    parameter int FRAME_GAP = 4
) (
    input  logic             clk_100k,
    input  logic             rst_n,
    input  logic             en,
    input  logic             adc_sdo,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic [OUT_W-1:0] samp_out,
    output logic             samp_valid,
    input  logic             samp_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int WAIT_MAX = (SCLK_DIV > FRAME_GAP) ? SCLK_DIV : FRAME_GAP;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int BW       = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

    adc_state_t          state_q, state_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic [ADC_BITS-1:0] raw_q, raw_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [OUT_W-1:0]    samp_out_q, samp_out_d;
    logic                samp_valid_q, samp_valid_d;
    logic                overrun_q, overrun_d;

    logic             rise_tick, fall_tick, period_done;
    logic             publish, accept, overwrite;
    logic [OUT_W-1:0] samp_conv;

    adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
        .clk         (clk_100k),
        .rst_n       (rst_n),
        .run         (state_q == SHIFT),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .period_done (period_done)
    );

    // Flipping the MSB turns offset binary into two's complement; low bits are dropped.
    assign samp_conv = {~raw_q[ADC_BITS-1], raw_q[ADC_BITS-2 -: OUT_W-1]};

    always_comb begin
        state_d      = state_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        raw_d        = raw_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        samp_out_d   = samp_out_q;
        samp_valid_d = samp_valid_q;
        overrun_d    = overrun_q;
        publish      = 1'b0;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (en) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            CS_SETUP: begin
                if (wait_cnt_q == WW'(SCLK_DIV - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (rise_tick) begin
                    sclk_d = 1'b1;
                    raw_d  = {raw_q[ADC_BITS-2:0], adc_sdo};
                end
                if (fall_tick) begin
                    sclk_d = 1'b0;
                end
                if (period_done) begin
                    if (bit_cnt_q == BW'(ADC_BITS - 1)) begin
                        bit_cnt_d = '0;
                        cs_n_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                publish = 1'b1;
                state_d = GAP;
            end
            GAP: begin
                if (wait_cnt_q == WW'(FRAME_GAP - 1)) begin
                    wait_cnt_d = '0;
                    if (en) begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        // A publish on the same edge as a hand-off keeps valid high.
        accept    = samp_valid_q && samp_ready;
        overwrite = publish && samp_valid_q && !samp_ready;
        if (publish) begin
            samp_out_d   = samp_conv;
            samp_valid_d = 1'b1;
        end else if (accept) begin
            samp_valid_d = 1'b0;
        end
        if (overwrite) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100k) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            raw_q        <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            samp_out_q   <= '0;
            samp_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            raw_q        <= raw_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            samp_out_q   <= samp_out_d;
            samp_valid_q <= samp_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign adc_cs_n   = cs_n_q;
    assign adc_sclk   = sclk_q;
    assign samp_out   = samp_out_q;
    assign samp_valid = samp_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_spi_rx.sv
// Bench for adc_spi_rx: default instance plus a SCLK_DIV=1/FRAME_GAP=1 instance, each fed by an ADC model.
module tb_adc_spi_rx;

    typedef struct {
        logic [11:0] raw;
        logic [8:0]  exp;
    } vec_t;

    logic       clk_100k = 1'b0;
    logic       rst_n, en, samp_ready, overrun_clr;
    logic       adc_sdo, adc_cs_n, adc_sclk, samp_valid, overrun;
    logic [8:0] samp_out;
    logic       en6, samp_ready6, adc_sdo6, adc_cs_n6, adc_sclk6, samp_valid6, overrun6;
    logic [8:0] samp_out6;

    always #5 clk_100k = ~clk_100k;

    adc_spi_rx u_dut (
        .clk_100k(clk_100k), .rst_n(rst_n), .en(en), .adc_sdo(adc_sdo),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .samp_out(samp_out),
        .samp_valid(samp_valid), .samp_ready(samp_ready), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    adc_spi_rx #(.SCLK_DIV(1), .FRAME_GAP(1)) u_dut6 (
        .clk_100k(clk_100k), .rst_n(rst_n), .en(en6), .adc_sdo(adc_sdo6),
        .adc_cs_n(adc_cs_n6), .adc_sclk(adc_sclk6), .samp_out(samp_out6),
        .samp_valid(samp_valid6), .samp_ready(samp_ready6), .overrun(overrun6),
        .overrun_clr(1'b0)
    );

    vec_t       word_q[$];
    logic [8:0] exp_q[$];
    int total = 0, bad = 0, cyc = 0;
    int xfers = 0, pulses = 0, rises = 0, cs_falls = 0, cs_rises = 0, last_cyc = 0;
    bit per_chk = 1'b0, sclk_chk = 1'b0, prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk_100k) cyc++;

    // ADC model: loads the next word when CS falls, advances a bit after each SCLK fall.
    logic [11:0] cur_w = 12'h800;
    logic [3:0]  bidx = 4'd11;
    always @(negedge adc_cs_n) begin
        vec_t v;
        v.raw = 12'h800;
        v.exp = 9'h000;
        if (word_q.size() > 0) v = word_q.pop_front();
        cur_w = v.raw;
        exp_q.push_back(v.exp);
        bidx = 4'd11;
        rises = 0;
        cs_falls++;
    end
    always @(negedge adc_sclk) if (bidx != 0) bidx--;
    assign adc_sdo = cur_w[bidx];

    logic [11:0] cur_w6 = 12'hA5C;
    logic [3:0]  bidx6 = 4'd11;
    always @(negedge adc_cs_n6) bidx6 = 4'd11;
    always @(negedge adc_sclk6) if (bidx6 != 0) bidx6--;
    assign adc_sdo6 = cur_w6[bidx6];

    always @(posedge adc_sclk) rises++;
    always @(posedge adc_cs_n) begin
        cs_rises++;
        if (sclk_chk) check("sclk_rises", rises, 12);
    end

    // Scoreboard: each hand-off is checked against the word the ADC model sent.
    always @(negedge clk_100k) begin
        if (samp_valid && !prev_v) pulses++;
        prev_v = samp_valid;
        if (samp_valid && samp_ready) begin
            xfers++;
            if (exp_q.size() == 0) check("sb_depth", 0, 1);
            else check("sample", samp_out, exp_q.pop_front());
            if (per_chk && last_cyc != 0) check("period", cyc - last_cyc, 55);
            last_cyc = cyc;
        end
    end

    initial begin
        vec_t       tbl[10];
        int         x0, p0, f0, r0, c1;
        logic [8:0] dummy;

        tbl[0] = '{12'hFFF, 9'h0FF};
        tbl[1] = '{12'h000, 9'h100};
        tbl[2] = '{12'h800, 9'h000};
        tbl[3] = '{12'h7FF, 9'h1FF};
        tbl[4] = '{12'h801, 9'h000};
        tbl[5] = '{12'hA5C, 9'h04B};
        tbl[6] = '{12'h123, 9'h124};
        tbl[7] = '{12'h001, 9'h100};
        tbl[8] = '{12'h7F8, 9'h1FF};
        tbl[9] = '{12'hFF8, 9'h0FF};

        rst_n = 1'b0; en = 1'b0; samp_ready = 1'b0; overrun_clr = 1'b0;
        en6 = 1'b0; samp_ready6 = 1'b1;
        repeat (3) @(negedge clk_100k);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 0);
        check("rst_valid", samp_valid, 0);
        check("rst_samp", samp_out, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // reset in the middle of a frame aborts it
        samp_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 20 && adc_cs_n; i++) @(negedge clk_100k);
        repeat (20) @(negedge clk_100k);
        check("mid_shift_cs", adc_cs_n, 0);
        rst_n = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk_100k);
        check("abort_cs_n", adc_cs_n, 1);
        check("abort_sclk", adc_sclk, 0);
        check("abort_valid", samp_valid, 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk_100k);
        check("abort_xfers", xfers, 0);
        check("abort_pulses", pulses, 0);
        exp_q.delete();

        // back-to-back frames with the consumer always ready
        foreach (tbl[k]) word_q.push_back(tbl[k]);
        sclk_chk = 1'b1; per_chk = 1'b1; last_cyc = 0;
        x0 = xfers; p0 = pulses; en = 1'b1;
        for (int i = 0; i < 800 && xfers < x0 + 10; i++) @(negedge clk_100k);
        en = 1'b0;
        check("tbl_xfers", xfers - x0, 10);
        repeat (80) @(negedge clk_100k);
        per_chk = 1'b0;
        check("tbl_pulses", pulses - p0, 10);
        check("tbl_sb_empty", exp_q.size(), 0);
        check("tbl_overrun", overrun, 0);
        check("tbl_idle_cs", adc_cs_n, 1);

        // en dropped mid-shift: frame finishes, then idle
        x0 = xfers; f0 = cs_falls;
        word_q.push_back('{12'h7FF, 9'h1FF});
        en = 1'b1;
        for (int i = 0; i < 20 && adc_cs_n; i++) @(negedge clk_100k);
        repeat (20) @(negedge clk_100k);
        check("drop_in_shift", adc_cs_n, 0);
        en = 1'b0;
        repeat (100) @(negedge clk_100k);
        check("drop_xfers", xfers - x0, 1);
        check("drop_frames", cs_falls - f0, 1);
        check("drop_cs_n", adc_cs_n, 1);
        check("drop_sb_empty", exp_q.size(), 0);

        // two publishes with no consumer: overwrite and sticky overrun
        samp_ready = 1'b0;
        word_q.push_back('{12'h123, 9'h124});
        word_q.push_back('{12'hE00, 9'h0C0});
        r0 = cs_rises; en = 1'b1;
        for (int i = 0; i < 300 && cs_rises < r0 + 2; i++) @(negedge clk_100k);
        en = 1'b0;
        check("ovr_frames", cs_rises - r0, 2);
        repeat (6) @(negedge clk_100k);
        check("ovr_valid", samp_valid, 1);
        check("ovr_samp", samp_out, 9'h0C0);
        check("ovr_flag", overrun, 1);
        dummy = exp_q.pop_front();
        x0 = xfers;
        samp_ready = 1'b1;
        @(negedge clk_100k);
        @(negedge clk_100k);
        samp_ready = 1'b0;
        check("ovr_xfer", xfers - x0, 1);
        check("ovr_valid_low", samp_valid, 0);
        check("ovr_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk_100k);
        overrun_clr = 1'b0;
        @(negedge clk_100k);
        check("ovr_cleared", overrun, 0);

        // fast instance: one-cycle half periods, one-cycle gap
        en6 = 1'b1;
        for (int i = 0; i < 100 && !samp_valid6; i++) @(negedge clk_100k);
        check("d1_valid_a", samp_valid6, 1);
        check("d1_samp", samp_out6, 9'h04B);
        c1 = cyc;
        @(negedge clk_100k);
        check("d1_pulse", samp_valid6, 0);
        for (int i = 0; i < 100 && !samp_valid6; i++) @(negedge clk_100k);
        check("d1_valid_b", samp_valid6, 1);
        check("d1_period", cyc - c1, 27);
        en6 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
